// File: rtl/xt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// xt_seq_ctrl -- sequencing controller for the XT (translate) stage.
//
// Classifies every incoming instruction word, latches it together with its PC,
// and steps a micro-op index through the expansion of the macro instructions
// JSRui, BSRsr, BSRso (call sequence) and RET (return sequence). While a
// multi-step expansion is in progress ow_busy tells fetch/decode to hold
// iw_pc/iw_instr. Flush and stall from pipeline control are applied here.
//
// Ports
//   iw_clk     in   clock
//   iw_rst_n   in   synchronous active-low reset
//   iw_pc      in   PC of iw_instr
//   iw_instr   in   instruction word from upstream
//   iw_flush   in   pipeline flush (abandons any expansion)
//   iw_stall   in   pipeline stall (every register holds)
//   ow_pc      out  latched PC of the current instruction
//   ow_instr   out  latched instruction word
//   ow_cls     out  class: 0 PASS, 1 JSR, 2 BSRSR, 3 BSRSO, 4 RET, 5 SETSSP, 6 BTP
//   ow_step    out  current micro-op index
//   ow_valid   out  ow_* describe a step to emit this cycle
//   ow_last    out  current step is the final one of its instruction
//   ow_busy    out  upstream must hold iw_pc/iw_instr
// -----------------------------------------------------------------------------

// Default field widths and opcode encodings; a project-wide definitions file
// included ahead of this one takes precedence.
`ifndef HBIT_ADDR
`define HBIT_ADDR 15
`endif
`ifndef HBIT_OPC
`define HBIT_OPC 7
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef OPC_NOP
`define OPC_NOP    8'h00
`define OPC_JCCUI  8'h01
`define OPC_BCCSR  8'h02
`define OPC_BALSO  8'h03
`define OPC_JSRUI  8'h10
`define OPC_BSRSR  8'h11
`define OPC_BSRSO  8'h12
`define OPC_RET    8'h13
`define OPC_SETSSP 8'h14
`define OPC_BTP    8'h15
`endif

module xt_seq_ctrl #(
    parameter int unsigned P_CALL_LEN = 4,  // push LR x2, LR<-PC, branch
    parameter int unsigned P_RET_LEN  = 3   // SSP+=2, load LR, jump
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst_n,
    input  logic [`HBIT_ADDR:0]   iw_pc,
    input  logic [`HBIT_DATA:0]   iw_instr,
    input  logic                  iw_flush,
    input  logic                  iw_stall,
    output logic [`HBIT_ADDR:0]   ow_pc,
    output logic [`HBIT_DATA:0]   ow_instr,
    output logic [2:0]            ow_cls,
    output logic [1:0]            ow_step,
    output logic                  ow_valid,
    output logic                  ow_last,
    output logic                  ow_busy
);

    // The step counter is 2 bits wide, so no sequence may exceed 4 steps.
    if (P_CALL_LEN < 1 || P_CALL_LEN > 4 || P_RET_LEN < 1 || P_RET_LEN > 4) begin : g_len_check
        $error("xt_seq_ctrl: P_CALL_LEN and P_RET_LEN must lie in 1..4");
    end

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } state_t;

    typedef enum logic [2:0] {
        CLS_PASS   = 3'd0,
        CLS_JSR    = 3'd1,
        CLS_BSRSR  = 3'd2,
        CLS_BSRSO  = 3'd3,
        CLS_RET    = 3'd4,
        CLS_SETSSP = 3'd5,
        CLS_BTP    = 3'd6
    } cls_t;

    localparam logic [2:0] L_CALL_LEN = 3'(P_CALL_LEN);
    localparam logic [2:0] L_RET_LEN  = 3'(P_RET_LEN);
    localparam logic [`HBIT_DATA:0] L_NOP_WORD = {`OPC_NOP, 16'b0};

    state_t                 state_q;
    cls_t                   cls_q;
    logic [1:0]             step_q;
    logic [2:0]             len_q;
    logic [`HBIT_DATA:0]    instr_q;
    logic [`HBIT_ADDR:0]    pc_q;
    logic                   valid_q;
    logic                   busy_q;

    // Decode of the incoming word; only consumed on an accepting IDLE edge.
    logic [`HBIT_OPC:0]     opc;
    cls_t                   cls_d;
    logic [2:0]             len_d;
    logic                   last_step;

    assign opc = iw_instr[`HBIT_DATA -: `HBIT_OPC+1];

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cls_d = CLS_PASS;
        len_d = 3'd1;
        unique case (opc)
            `OPC_JSRUI:  begin cls_d = CLS_JSR;    len_d = L_CALL_LEN; end
            `OPC_BSRSR:  begin cls_d = CLS_BSRSR;  len_d = L_CALL_LEN; end
            `OPC_BSRSO:  begin cls_d = CLS_BSRSO;  len_d = L_CALL_LEN; end
            `OPC_RET:    begin cls_d = CLS_RET;    len_d = L_RET_LEN;  end
            `OPC_SETSSP: cls_d = CLS_SETSSP;
            `OPC_BTP:    cls_d = CLS_BTP;
            default:     ;
        endcase
    end

    assign last_step = ({1'b0, step_q} == (len_q - 3'd1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= 2'd0;
            len_q   <= 3'd1;
            cls_q   <= CLS_PASS;
            instr_q <= L_NOP_WORD;
            pc_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (iw_flush) begin
            // Same as reset except the PC, which stays for the redirect logic.
            state_q <= ST_IDLE;
            step_q  <= 2'd0;
            len_q   <= 3'd1;
            cls_q   <= CLS_PASS;
            instr_q <= L_NOP_WORD;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (!iw_stall) begin
            if (state_q == ST_IDLE) begin
                instr_q <= iw_instr;
                pc_q    <= iw_pc;
                cls_q   <= cls_d;
                len_q   <= len_d;
                step_q  <= 2'd0;
                valid_q <= 1'b1;
                if (len_d > 3'd1) begin
                    state_q <= ST_EXPAND;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            end else if (last_step) begin
                // Final step emitted: spend one bubble cycle with busy low so
                // upstream can present the held word on the next edge.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                step_q  <= 2'd0;
            end else begin
                step_q <= step_q + 2'd1;
            end
        end
    end

    assign ow_pc    = pc_q;
    assign ow_instr = instr_q;
    assign ow_cls   = cls_q;
    assign ow_step  = step_q;
    assign ow_valid = valid_q;
    assign ow_busy  = busy_q;
    assign ow_last  = valid_q && last_step;

endmodule

// File: doc/xt_seq_ctrl.md
Name: xt_seq_ctrl

Overview:
- Sequencing controller for the XT (translate) stage.
- Classifies each incoming instruction word and latches macro instructions (JSRui, BSRsr, BSRso, RET) with their PC.
- Steps a micro-op index through each expansion and raises a hold toward fetch/decode while an expansion is in progress.
- Its outputs drive the XT micro-op packers; flush and stall from the pipeline control are applied here.

Parameters:
- P_CALL_LEN, 4, micro-op count for JSRui/BSRsr/BSRso (push LR ×2, LR←PC, branch).
- P_RET_LEN, 3, micro-op count for RET (SSP+=2, load LR, jump).

Ports:
- iw_clk  in  1  clock.
- iw_rst_n  in  1  synchronous active-low reset.
- iw_pc  in  `HBIT_ADDR+1  PC of iw_instr.
- iw_instr  in  `HBIT_DATA+1  instruction word from upstream.
- iw_flush  in  1  pipeline flush.
- iw_stall  in  1  pipeline stall (freeze).
- ow_pc  out  `HBIT_ADDR+1  latched PC of the current instruction.
- ow_instr  out  `HBIT_DATA+1  latched instruction word.
- ow_cls  out  3  class: 0 PASS, 1 JSR, 2 BSRSR, 3 BSRSO, 4 RET, 5 SETSSP, 6 BTP.
- ow_step  out  2  current micro-op index.
- ow_valid  out  1  ow_* describe a step to emit this cycle.
- ow_last  out  1  current step is the final one of its instruction.
- ow_busy  out  1  upstream must hold iw_pc/iw_instr.

Behaviour:
- State: r_state {IDLE, EXPAND}, r_step[1:0], r_len[2:0], r_cls, r_instr, r_pc, r_valid; all outputs registered except ow_last.
- Length rule:
  - LEN = P_CALL_LEN for JSR/BSRSR/BSRSO.
  - LEN = P_RET_LEN for RET.
  - LEN = 1 otherwise (PASS, SETSSP, BTP).
- Class decoding uses the `OPC_* macros on iw_instr[`HBIT_DATA -: `HBIT_OPC+1].
- Edge priority: reset > flush > stall > normal.
- Reset (iw_rst_n=0 at edge):
  - IDLE, step 0, len 1, cls 0.
  - ow_instr={`OPC_NOP,16'b0}, ow_pc=0.
  - ow_valid=0, ow_busy=0.
- Flush: same values as reset, except ow_pc holds. An expansion in progress is abandoned mid-sequence, with no further steps.
- Stall: every register holds; ow_busy is unchanged.
- IDLE, normal edge:
  - Latch instr, pc, cls and len; step←0; valid←1.
  - If LEN>1: state←EXPAND, busy←1. Otherwise stay IDLE, busy←0.
  - Single-step instructions therefore stream back-to-back, one per cycle.
- EXPAND, normal edge:
  - If step==len-1: state←IDLE, busy←0, valid←0, step←0. This is one bubble cycle; the held word is sampled on the following edge.
  - Else: step←step+1.
- ow_last = r_valid && (r_step == r_len-1), combinational.
- Handshake with upstream:
  - Upstream advances on the edge that enters EXPAND, because busy was 0 then.
  - It holds while busy=1.
  - It advances again at the end of the bubble cycle.
- Step counter never exceeds len-1; P_* values >4 are illegal.
- Flush and stall together: flush wins.
- Reset asserted during EXPAND: reset values on that edge.

Test Plan:
- Reset, then stream JCCui, BCCsr, BALso on consecutive cycles.
  - Required: ow_valid=1 each cycle, ow_cls=0, ow_step=0, ow_last=1, ow_busy=0.
  - ow_instr tracks the input with one cycle of latency.
- JSRui 0xABC at pc=0x10.
  - Required: ow_step 0,1,2,3 on four consecutive cycles, ow_cls=1, ow_pc=0x10.
  - ow_busy=1 throughout; ow_last only at step 3.
  - Then one cycle with ow_valid=0, busy=0.
- RET followed by SETSSP held upstream.
  - Required: steps 0..2 with cls=4, then a bubble.
  - Then SETSSP: cls=5, step 0, last=1.
- BSRso with iw_stall=1 for two cycles at step 1.
  - Required: ow_step stays 1 and busy stays 1 during the stall; steps 2 and 3 follow after release.
- BSRsr with iw_flush=1 at step 2.
  - Required next cycle: valid=0, busy=0, state IDLE, ow_instr=NOP, ow_pc unchanged.
  - The next word is accepted on the following edge.
- iw_rst_n=0 during JSR step 1.
  - Required: all outputs at reset values on the next cycle; normal operation resumes after release.
